// File: rtl/rr_stream_arbiter.sv
// rr_stream_arbiter: round-robin merge of NUM_IN valid/ready streams into one registered output stream
//   clk, srst          clock, synchronous active-high reset
//   in_valid/in_ready  per-input handshake (in_ready is one-hot or zero, combinational from out_ready)
//   in_data/in_last    per-input beat, input i at in_data[i*WIDTH +: WIDTH]
//   out_valid/out_ready, out_data/out_last/out_src  registered output beat and its source index
//   Optional ARB_PACKET_LOCK_EN: hold the grant on one input until its last beat.
module rr_stream_arbiter #(
  parameter int NUM_IN = 4,
  parameter int WIDTH = 32,
  localparam int IDW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_last,
  output logic [IDW-1:0]          out_src
);
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [WIDTH-1:0] out_data_q, out_data_d, sel_data;
  logic [IDW-1:0]   out_src_q, out_src_d, ptr_q, ptr_d, rr_grant, grant, nxt_ptr;
  logic             grant_valid, load, xfer, sel_last;
  // Lowest valid index overall is the wrap-around candidate; lowest valid at or above ptr overrides it.
  always_comb begin
    rr_grant = ptr_q;
    for (int i = NUM_IN-1; i >= 0; i--) if (in_valid[i]) rr_grant = IDW'(i);
    for (int i = NUM_IN-1; i >= 0; i--) if (in_valid[i] && IDW'(i) >= ptr_q) rr_grant = IDW'(i);
  end
`ifdef ARB_PACKET_LOCK_EN
  localparam logic [0:0] IDLE = 1'b0, LOCKED = 1'b1;
  localparam bit LOCK_EN = 1'b1;
  logic [0:0]     state_q, state_d;
  logic [IDW-1:0] lock_q, lock_d;
  assign grant = (state_q == LOCKED) ? lock_q : rr_grant;
  assign grant_valid = (state_q == LOCKED) ? in_valid[lock_q] : |in_valid;
  assign state_d = xfer ? (sel_last ? IDLE : LOCKED) : state_q;
  assign lock_d = (xfer && !sel_last) ? grant : lock_q;
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q <= IDLE;
      lock_q <= '0;
    end else begin
      state_q <= state_d;
      lock_q <= lock_d;
    end
  end
`else
  localparam bit LOCK_EN = 1'b0;
  assign grant = rr_grant;
  assign grant_valid = |in_valid;
`endif
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_IN; i++) if (grant == IDW'(i)) sel_data = in_data[i*WIDTH +: WIDTH];
  end
  assign sel_last = in_last[grant];
  // Refill the output register whenever it is empty or draining this cycle.
  assign load = !out_valid_q || out_ready;
  assign xfer = grant_valid && load && !srst;
  assign in_ready = xfer ? (NUM_IN'(1) << grant) : '0;
  // Explicit compare keeps the wrap correct for non-power-of-two NUM_IN.
  assign nxt_ptr = (grant == IDW'(NUM_IN-1)) ? '0 : grant + IDW'(1);
  assign ptr_d = (xfer && (sel_last || !LOCK_EN)) ? nxt_ptr : ptr_q;
  assign out_valid_d = load ? xfer : out_valid_q;
  assign out_data_d = xfer ? sel_data : out_data_q;
  assign out_last_d = xfer ? sel_last : out_last_q;
  assign out_src_d = xfer ? grant : out_src_q;
  always_ff @(posedge clk) begin
    if (srst) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_src_q <= '0;
      ptr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
      out_src_q <= out_src_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_last = out_last_q;
  assign out_src = out_src_q;
endmodule

// File: tb/tb_rr_stream_arbiter.sv
// tb_rr_stream_arbiter: scoreboard bench for rr_stream_arbiter (NUM_IN=4 main instance, NUM_IN=3 wrap instance)
module tb_rr_stream_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic srst;
  logic [3:0] in_valid, in_ready, in_last;
  logic [127:0] in_data;
  logic out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [1:0] out_src;
  logic [2:0] v3, r3, l3;
  logic [95:0] d3;
  logic ov3, ordy3, ol3;
  logic [31:0] od3;
  logic [1:0] os3;
  rr_stream_arbiter #(.NUM_IN(4), .WIDTH(32)) dut (
    .clk(clk), .srst(srst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_src(out_src));
  rr_stream_arbiter #(.NUM_IN(3), .WIDTH(32)) dut3 (
    .clk(clk), .srst(srst), .in_valid(v3), .in_ready(r3), .in_data(d3),
    .in_last(l3), .out_valid(ov3), .out_ready(ordy3), .out_data(od3),
    .out_last(ol3), .out_src(os3));
  typedef struct {int dly; logic last; logic [31:0] data;} beat_t;
  typedef struct {logic [1:0] src; logic [31:0] data; logic last;} exp_t;
  beat_t fq[4][$];
  exp_t sb[$];
  logic [3:0] ir_hist[$];
  int tests = 0, fails = 0;
  logic s_ov, s_ol;
  logic [31:0] s_od;
  logic [1:0] s_os;
  logic [3:0] s_ir;
  function automatic logic [31:0] mk(int i, int n);
    return 32'hD000_0000 + 32'(i * 256 + n);
  endfunction
  task automatic push_beat(int i, int n, logic last, int dly);
    beat_t b;
    b.dly = dly; b.last = last; b.data = mk(i, n);
    fq[i].push_back(b);
  endtask
  task automatic expect_beat(int i, int n, logic last);
    exp_t e;
    e.src = 2'(i); e.data = mk(i, n); e.last = last;
    sb.push_back(e);
  endtask
  // Bench-side FWFT FIFOs: a head beat with dly>0 stays invisible for dly cycles.
  task automatic update_inputs(logic [3:0] hs);
    for (int i = 0; i < 4; i++) begin
      if (hs[i] && fq[i].size() > 0) void'(fq[i].pop_front());
      if (fq[i].size() > 0 && fq[i][0].dly == 0) begin
        in_valid[i] = 1'b1; in_data[i*32 +: 32] = fq[i][0].data; in_last[i] = fq[i][0].last;
      end else begin
        in_valid[i] = 1'b0; in_data[i*32 +: 32] = '0; in_last[i] = 1'b0;
      end
      if (fq[i].size() > 0 && fq[i][0].dly > 0) fq[i][0].dly = fq[i][0].dly - 1;
    end
  endtask
  function automatic bit busy();
    bit b = sb.size() > 0;
    for (int i = 0; i < 4; i++) if (fq[i].size() > 0) b = 1'b1;
    return b;
  endfunction
  task automatic tick();
    logic [3:0] hs;
    exp_t e;
    @(negedge clk);
    s_ov = out_valid; s_od = out_data; s_os = out_src; s_ol = out_last; s_ir = in_ready;
    ir_hist.push_back(in_ready);
    hs = in_valid & in_ready;
    tests++;
    if ((in_ready & (in_ready - 4'd1)) !== 4'd0) begin
      fails++; $display("FAIL onehot: in_ready=%b, required one-hot or zero", in_ready);
    end
    if (out_valid && out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++; $display("FAIL extra_beat: src=%0d data=%h, required no beat", out_src, out_data);
      end else begin
        e = sb.pop_front();
        if ({out_src, out_data, out_last} !== {e.src, e.data, e.last}) begin
          fails++;
          $display("FAIL beat: got src=%0d data=%h last=%b, required src=%0d data=%h last=%b",
                   out_src, out_data, out_last, e.src, e.data, e.last);
        end
      end
    end
    @(posedge clk); #1;
    update_inputs(hs);
  endtask
  task automatic run_drain(output int n, input int budget);
    n = 0;
    while (busy() && n < budget) begin tick(); n++; end
    tests++;
    if (busy()) begin
      fails++; $display("FAIL drain_timeout: %0d beats left after %0d cycles, required 0", sb.size(), n);
      sb.delete();
      for (int i = 0; i < 4; i++) fq[i].delete();
      update_inputs('0);
    end
  endtask
  task automatic check_int(string name, int got, int req);
    tests++;
    if (got !== req) begin fails++; $display("FAIL %s: got %0d, required %0d", name, got, req); end
  endtask
  task automatic test_reset();
    srst = 1'b1; in_valid = 4'hF; in_data = {4{32'hCAFE_F00D}}; in_last = 4'hF; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_int("rst_out_valid", int'(out_valid), 0);
    check_int("rst_out_data", int'(out_data), 0);
    check_int("rst_out_last", int'(out_last), 0);
    check_int("rst_out_src", int'(out_src), 0);
    check_int("rst_in_ready", int'(in_ready), 0);
    check_int("rst_out_valid3", int'(ov3), 0);
    @(posedge clk); #1;
    srst = 1'b0;
    update_inputs('0);
  endtask
  task automatic test_round_robin();
    int c;
    for (int n = 0; n < 2; n++) for (int i = 0; i < 4; i++) begin
      push_beat(i, n, 1'b1, 0); expect_beat(i, n, 1'b1);
    end
    update_inputs('0);
    run_drain(c, 30);
    check_int("rr_cycles", c, 9);
  endtask
  task automatic test_single();
    int c;
    push_beat(2, 0, 1'b1, 0); expect_beat(2, 0, 1'b1);
    update_inputs('0);
    run_drain(c, 10);
    check_int("single_cycles", c, 2);
    push_beat(0, 1, 1'b1, 0); push_beat(3, 1, 1'b1, 0);
    expect_beat(3, 1, 1'b1); expect_beat(0, 1, 1'b1);
    update_inputs('0);
    run_drain(c, 10);
    check_int("after2_cycles", c, 3);
  endtask
  task automatic test_packet_lock();
    int c, first0, req_c, req_first0;
    push_beat(0, 2, 1'b1, 0);
    push_beat(1, 2, 1'b0, 0); push_beat(1, 3, 1'b0, 2); push_beat(1, 4, 1'b1, 0);
    push_beat(2, 2, 1'b1, 0);
`ifdef ARB_PACKET_LOCK_EN
    expect_beat(1, 2, 1'b0); expect_beat(1, 3, 1'b0); expect_beat(1, 4, 1'b1);
    expect_beat(2, 2, 1'b1); expect_beat(0, 2, 1'b1);
    req_c = 8; req_first0 = 6;
`else
    expect_beat(1, 2, 1'b0); expect_beat(2, 2, 1'b1); expect_beat(0, 2, 1'b1);
    expect_beat(1, 3, 1'b0); expect_beat(1, 4, 1'b1);
    req_c = 6; req_first0 = 2;
`endif
    ir_hist.delete();
    update_inputs('0);
    run_drain(c, 20);
    check_int("lock_cycles", c, req_c);
    first0 = -1;
    foreach (ir_hist[k]) if (first0 < 0 && ir_hist[k][0]) first0 = k;
    check_int("lock_first_ready0", first0, req_first0);
  endtask
  task automatic test_hold();
    int c;
    for (int n = 0; n < 3; n++) begin push_beat(3, 10 + n, 1'b1, 0); expect_beat(3, 10 + n, 1'b1); end
    out_ready = 1'b0;
    update_inputs('0);
    tick();
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++;
      if ({s_ov, s_od, s_os, s_ir} !== {1'b1, mk(3, 10), 2'd3, 4'd0}) begin
        fails++;
        $display("FAIL hold: valid=%b data=%h src=%0d in_ready=%b, required 1 %h 3 0000",
                 s_ov, s_od, s_os, s_ir, mk(3, 10));
      end
    end
    out_ready = 1'b1;
    run_drain(c, 10);
    check_int("hold_resume_cycles", c, 3);
  endtask
  task automatic test_reset_mid_packet();
    int c;
    push_beat(1, 20, 1'b0, 0); push_beat(1, 21, 1'b0, 0); push_beat(1, 22, 1'b1, 0);
    push_beat(2, 20, 1'b1, 0);
    expect_beat(1, 20, 1'b0);
    out_ready = 1'b0;
    update_inputs('0);
    tick();
    srst = 1'b1; out_ready = 1'b1;
    tick();
    check_int("srst_in_ready", int'(s_ir), 0);
    srst = 1'b0;
    sb.delete();
    for (int i = 0; i < 4; i++) fq[i].delete();
    for (int i = 0; i < 3; i++) begin push_beat(i, 30, 1'b1, 0); expect_beat(i, 30, 1'b1); end
    update_inputs('0);
    tick();
    check_int("post_srst_out_valid", int'(s_ov), 0);
    run_drain(c, 10);
    check_int("post_srst_cycles", c, 3);
  endtask
  task automatic test_wrap3();
    int q3[$];
    int got = 0;
    int e;
    v3 = 3'b111; l3 = 3'b111; ordy3 = 1'b1;
    d3 = {mk(2, 0), mk(1, 0), mk(0, 0)};
    for (int k = 0; k < 6; k++) q3.push_back(k % 3);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (ov3) begin
        tests++;
        if (q3.size() == 0) begin
          fails++; $display("FAIL wrap3_extra: src=%0d, required no beat", os3);
        end else begin
          e = q3.pop_front();
          if ({os3, od3, ol3} !== {2'(e), mk(e, 0), 1'b1}) begin
            fails++; $display("FAIL wrap3: got src=%0d data=%h, required src=%0d data=%h", os3, od3, e, mk(e, 0));
          end
        end
        got++;
      end
      @(posedge clk); #1;
    end
    v3 = '0;
    check_int("wrap3_beats", got, 6);
  endtask
  initial begin
    srst = 1'b1; in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b0;
    v3 = '0; d3 = '0; l3 = '0; ordy3 = 1'b0;
    test_reset();
    test_round_robin();
    test_single();
    test_packet_lock();
    test_hold();
    test_reset_mid_packet();
    test_wrap3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_stream_arbiter.md
Name: rr_stream_arbiter

Overview:
- Merges NUM_IN valid/ready message streams into one output stream using round-robin arbitration.
- Sits directly downstream of a bank of fifo_wrapper instances. Each input connects to one FIFO's output_valid / output_ready / output_data. The single output feeds the inter-FPGA link serializer.
- Has a registered output stage, full throughput, and multi-beat packet locking.

Parameters:
- NUM_IN, 4, number of input streams (>=2, need not be a power of 2)
- WIDTH, 32, data width per beat
- IDW, derived localparam, max(1, $clog2(NUM_IN)), source index width

Ports:
- clk  input  1  clock
- srst  input  1  synchronous reset, active-high
- in_valid  input  NUM_IN  per-input valid (FIFO not empty)
- in_ready  output  NUM_IN  per-input ready (drives FIFO rd_en)
- in_data  input  NUM_IN*WIDTH  input i occupies bits [i*WIDTH +: WIDTH]
- in_last  input  NUM_IN  per-input last-beat-of-packet flag
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream ready
- out_data  output  WIDTH  output beat data
- out_last  output  1  copy of the accepted beat's in_last
- out_src  output  IDW  index of the input that supplied the beat

Behaviour:
- Interface: reset srst, synchronous, active-high; clock clk.
- Reset values: out_valid=0, out_data=0, out_last=0, out_src=0, rr pointer ptr=0, state=IDLE.
- Reset mid-packet drops the lock and the output register contents. in_ready is all-zero during the srst cycle.
- Load condition: load = !out_valid || out_ready. This gives full throughput: one beat per cycle under continuous valid and ready.
- in_ready[i] = (i == grant) && grant_valid && load && !srst. in_ready is one-hot or zero, combinational from out_ready. This is legal because FWFT FIFOs tolerate combinational rd_en.
- Transfer on input i: in_valid[i] && in_ready[i]. The beat is registered into out_data/out_last/out_src with out_valid=1 on the next edge. Latency is 1 cycle.
- If load && no input is transferred, then out_valid <= 0 on the next edge.
- Output hold: while out_valid && !out_ready, all outputs stay stable.
- State IDLE:
  - grant = the first i with in_valid[i], searching ptr, ptr+1, ..., NUM_IN-1, 0, ..., ptr-1.
  - grant_valid = |in_valid.
  - On transfer with in_last=1: ptr <= (grant==NUM_IN-1) ? 0 : grant+1; stay IDLE.
  - On transfer with in_last=0: lock <= grant; go to LOCKED.
- State LOCKED:
  - grant = lock and grant_valid = in_valid[lock]. Other inputs are ignored even if valid.
  - A bubble on the locked input stalls the output; the grant does not switch.
  - On transfer with in_last=1: ptr <= lock+1 (wrapping at NUM_IN-1 to 0); go to IDLE.
- The pointer wraps by explicit compare with NUM_IN-1, not by bit overflow, to support non-power-of-2 NUM_IN.
- All arithmetic is on IDW-bit unsigned values.
- Simultaneous new request and output drain in the same cycle are handled by the load equation. No extra bubble is allowed.
- Data on inputs with in_ready=0 is never consumed.

Optional Feature:
- Macro: ARB_PACKET_LOCK_EN.
- Defined: LOCKED state and packet locking operate exactly as described above.
- Undefined:
  - The arbiter stays in IDLE permanently and re-arbitrates every beat.
  - ptr advances to grant+1 on every transfer regardless of in_last.
  - in_last is still passed through to out_last.

Test Plan:
- Reset, then in_valid=4'b1111, each with single-beat packets (last=1), out_ready=1 -> out_src sequence 0,1,2,3,0,... one beat per cycle; first out_valid the cycle after the first transfer.
- ptr=0, in_valid=4'b0100 only -> grant 2, out_src=2; next grant search starts at 3.
- ARB_PACKET_LOCK_EN defined, input 1 sends 3 beats (last on beat 3) with input 0 also valid, beat 2 of input 1 delayed 2 cycles -> out_src=1 for 3 consecutive output beats, in_ready[0]=0 throughout, then input 2 or 3 or 0 is granted.
- Same stimulus with the macro undefined -> beats interleave: out_src 1,2 (or the next valid) before input 1's beat 2.
- out_ready held 0 for 5 cycles with a beat pending -> out_valid=1 and out_data/out_src stable; in_ready=0 for all inputs; no FIFO beat lost. Releasing out_ready resumes 1 beat/cycle.
- Assert srst while LOCKED mid-packet -> next cycle out_valid=0, ptr=0, state IDLE; arbitration restarts at input 0.
- NUM_IN=3 run: ptr wraps 2->0; out_src never equals 3.
